// File: rtl/mm_arb_pkg.sv
// rtl/mm_arb_pkg.sv - shared constants and FSM state type for the register-port arbiter
package mm_arb_pkg;

    localparam logic [1:0] ADDR_FIFO = 2'd0;
    localparam logic [1:0] ADDR_STAT = 2'd1;
    localparam logic [1:0] ADDR_MEM  = 2'd2;
    localparam logic [1:0] ADDR_BAD  = 2'd3;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHK   = 3'd1,
        CHKW  = 3'd2,
        ISSUE = 3'd3,
        CAPT  = 3'd4,
        RESP  = 3'd5
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker, first request after last_grant wins
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last_grant,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            any
);

    int   cand;
    logic found;

    // scan from the requester after last_grant, wrapping, and keep the first hit
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = (int'(last_grant) + k) % NREQ;
            if (!found && req[IW'(cand)]) begin
                found            = 1'b1;
                gnt[IW'(cand)]   = 1'b1;
                idx              = IW'(cand);
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/mm_port_arbiter.sv
// rtl/mm_port_arbiter.sv - round-robin arbiter for the shared register port; MM_FULL_GUARD_EN adds FIFO status pre-check
module mm_port_arbiter
    import mm_arb_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [2*NREQ-1:0] req_addr,
    input  logic [NREQ-1:0]   req_write,
    input  logic [8*NREQ-1:0] req_wdata,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              mm_enable,
    output logic [1:0]        mm_addr,
    output logic              mm_write,
    output logic              mm_read,
    output logic [7:0]        mm_wdata,
    input  logic [7:0]        mm_rdata
);

    localparam int IW = $clog2(NREQ);

    state_t          state;
    state_t          state_n;
    logic [IW-1:0]   last_grant;
    logic [IW-1:0]   cur_idx;
    logic [1:0]      cur_addr;
    logic            cur_wr;
    logic [7:0]      cur_wdata;
    logic            err_q;
    logic [7:0]      rd_q;

    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic [1:0]      sel_addr;
    logic            sel_wr;
    logic [7:0]      sel_wdata;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .gnt        (pick_gnt),
        .idx        (pick_idx),
        .any        (pick_any)
    );

    assign sel_addr  = req_addr[2*int'(pick_idx) +: 2];
    assign sel_wr    = req_write[pick_idx];
    assign sel_wdata = req_wdata[8*int'(pick_idx) +: 8];

`ifdef MM_FULL_GUARD_EN
    logic chk_fail;
    // a FIFO write is refused when full, a FIFO read when empty
    assign chk_fail = cur_wr ? mm_rdata[STAT_FULL_BIT] : mm_rdata[STAT_EMPTY_BIT];
`endif

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // next-state logic; requests are only looked at in IDLE
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    if (sel_addr == ADDR_BAD) begin
                        state_n = RESP;
`ifdef MM_FULL_GUARD_EN
                    end else if (sel_addr == ADDR_FIFO) begin
                        state_n = CHK;
`endif
                    end else begin
                        state_n = ISSUE;
                    end
                end
            end
            CHK:     state_n = CHKW;
`ifdef MM_FULL_GUARD_EN
            CHKW:    state_n = chk_fail ? RESP : ISSUE;
`else
            CHKW:    state_n = IDLE;
`endif
            ISSUE:   state_n = CAPT;
            CAPT:    state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // transaction capture, read data capture and priority rotation
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= IW'(NREQ - 1);
            cur_idx    <= '0;
            cur_addr   <= '0;
            cur_wr     <= 1'b0;
            cur_wdata  <= '0;
            err_q      <= 1'b0;
            rd_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        cur_idx   <= pick_idx;
                        cur_addr  <= sel_addr;
                        cur_wr    <= sel_wr;
                        cur_wdata <= sel_wdata;
                        err_q     <= (sel_addr == ADDR_BAD);
                        rd_q      <= '0;
                    end
                end
`ifdef MM_FULL_GUARD_EN
                CHKW:    err_q <= chk_fail;
`endif
                CAPT:    rd_q <= cur_wr ? 8'd0 : mm_rdata;
                RESP:    last_grant <= cur_idx;
                default: ;
            endcase
        end
    end

    // outputs decoded from the current state; no accept while reset is asserted
    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        mm_enable = 1'b0;
        mm_addr   = '0;
        mm_write  = 1'b0;
        mm_read   = 1'b0;
        mm_wdata  = '0;
        case (state)
            IDLE: begin
                if (!rst && pick_any) begin
                    req_ready = pick_gnt;
                end
            end
            CHK: begin
                mm_enable = 1'b1;
                mm_read   = 1'b1;
                mm_addr   = ADDR_STAT;
            end
            ISSUE: begin
                mm_enable = 1'b1;
                mm_addr   = cur_addr;
                mm_write  = cur_wr;
                mm_read   = ~cur_wr;
                mm_wdata  = cur_wr ? cur_wdata : 8'd0;
            end
            RESP: begin
                rsp_valid[cur_idx] = 1'b1;
                rsp_rdata          = rd_q;
                rsp_err            = err_q;
            end
            default: ;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mm_port_arbiter.sv
// tb/tb_mm_port_arbiter.sv - randomized self-checking bench with transaction-level reference model
module tb_mm_port_arbiter;

    localparam int NREQ  = 4;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [2*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_write;
    logic [8*NREQ-1:0] req_wdata;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_rdata;
    logic              rsp_err;
    logic              busy;
    logic              mm_enable;
    logic [1:0]        mm_addr;
    logic              mm_write;
    logic              mm_read;
    logic [7:0]        mm_wdata;
    logic [7:0]        mm_rdata;

    mm_port_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mm_enable (mm_enable),
        .mm_addr   (mm_addr),
        .mm_write  (mm_write),
        .mm_read   (mm_read),
        .mm_wdata  (mm_wdata),
        .mm_rdata  (mm_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- register block environment ----------------
    logic [7:0] env_fifo[$];
    logic [7:0] env_mem = 8'd0;
    logic       e_rst, e_en, e_rd, e_wr;
    logic [1:0] e_addr;
    logic [7:0] e_wd;

    always @(negedge clk) begin
        e_rst = rst; e_en = mm_enable; e_rd = mm_read; e_wr = mm_write;
        e_addr = mm_addr; e_wd = mm_wdata;
    end

    always @(posedge clk) begin
        if (e_rst) begin
            env_fifo.delete();
            env_mem = 8'd0;
            mm_rdata <= 8'd0;
        end else if (e_en && e_rd) begin
            case (e_addr)
                2'd0:    mm_rdata <= (env_fifo.size() > 0) ? env_fifo.pop_front() : 8'd0;
                2'd1:    mm_rdata <= {6'd0, env_fifo.size() == DEPTH, env_fifo.size() == 0};
                2'd2:    mm_rdata <= env_mem;
                default: mm_rdata <= 8'd0;
            endcase
        end else begin
            if (e_en && e_wr) begin
                if (e_addr == 2'd0 && env_fifo.size() < DEPTH) env_fifo.push_back(e_wd);
                if (e_addr == 2'd2) env_mem = e_wd;
            end
            mm_rdata <= 8'($urandom);
        end
    end

    // ---------------- transaction-level reference model ----------------
    typedef struct { int c; logic [1:0] a; logic w; logic [7:0] d; } mm_ev_t;
    typedef struct { int c; int idx; logic [7:0] rd; logic err; } rsp_ev_t;

    mm_ev_t     mm_q[$];
    rsp_ev_t    rsp_q[$];
    logic [7:0] m_fifo[$];
    logic [7:0] m_mem = 8'd0;
    int         m_last = NREQ - 1;
    int         next_free = 0;
    int         grant_cyc = 0;
    int         gnt_cyc[NREQ] = '{default: -10};
    int         rsp_seen = 0;
    mm_ev_t     me;
    rsp_ev_t    re;

    task automatic model_grant(input int idx);
        logic [1:0] a;
        logic       w;
        logic [7:0] d;
        logic [7:0] rd;
        logic       err;
        int         lat;
        a = req_addr[2*idx +: 2];
        w = req_write[idx];
        d = req_wdata[8*idx +: 8];
        rd = 8'd0; err = 1'b0; lat = 3;
        if (a == 2'd3) begin
            err = 1'b1; lat = 1;
        end else begin
`ifdef MM_FULL_GUARD_EN
            if (a == 2'd0) begin
                mm_q.push_back('{cyc + 1, 2'd1, 1'b0, 8'd0});
                if (w ? (m_fifo.size() == DEPTH) : (m_fifo.size() == 0)) begin
                    err = 1'b1; lat = 3;
                end else begin
                    lat = 5;
                end
            end
`endif
            if (!err) begin
                mm_q.push_back('{cyc + lat - 2, a, w, w ? d : 8'd0});
                if (w) begin
                    if (a == 2'd0 && m_fifo.size() < DEPTH) m_fifo.push_back(d);
                    if (a == 2'd2) m_mem = d;
                end else begin
                    case (a)
                        2'd0:    rd = (m_fifo.size() > 0) ? m_fifo.pop_front() : 8'd0;
                        2'd1:    rd = {6'd0, m_fifo.size() == DEPTH, m_fifo.size() == 0};
                        default: rd = m_mem;
                    endcase
                end
            end
        end
        rsp_q.push_back('{cyc + lat, idx, rd, err});
        grant_cyc = cyc;
        next_free = cyc + lat + 1;
        m_last    = idx;
        gnt_cyc[idx] = cyc;
    endtask

    // monitor: compare every cycle against the model, then advance the model
    always @(negedge clk) begin
        int g;
        if (mm_q.size() > 0 && mm_q[0].c == cyc) begin
            me = mm_q.pop_front();
            check("mm_enable", 32'(mm_enable), 32'd1);
            check("mm_addr", 32'(mm_addr), 32'(me.a));
            check("mm_rw", {30'd0, mm_write, mm_read}, {30'd0, me.w, ~me.w});
            check("mm_wdata", 32'(mm_wdata), 32'(me.d));
        end else begin
            check("mm_quiet", {21'd0, mm_enable, mm_write, mm_read, mm_wdata}, 32'd0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].c == cyc) begin
            re = rsp_q.pop_front();
            rsp_seen++;
            check("rsp_valid", 32'(rsp_valid), 32'(1 << re.idx));
            check("rsp_rdata", 32'(rsp_rdata), 32'(re.rd));
            check("rsp_err", 32'(rsp_err), 32'(re.err));
        end else begin
            check("rsp_quiet", 32'(rsp_valid), 32'd0);
        end
        check("busy", 32'(busy), 32'(cyc > grant_cyc && cyc < next_free));
        if (rst) begin
            check("ready_in_rst", 32'(req_ready), 32'd0);
            mm_q.delete(); rsp_q.delete(); m_fifo.delete();
            m_mem = 8'd0; m_last = NREQ - 1;
            grant_cyc = cyc; next_free = cyc + 1;
        end else if (cyc >= next_free && |req_valid) begin
            g = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
            end
            check("req_ready", 32'(req_ready), 32'(1 << g));
            model_grant(g);
        end else begin
            check("ready_quiet", 32'(req_ready), 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [1:0] a, input logic w, input logic [7:0] d);
        req_addr[2*i +: 2]  = a;
        req_write[i]        = w;
        req_wdata[8*i +: 8] = d;
        req_valid[i]        = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy === 1'b1 && n < 20) begin tick(); n++; end
        check("idle_timeout", 32'(busy), 32'd0);
        tick();
    endtask

    task automatic do_req(input int i, input logic [1:0] a, input logic w, input logic [7:0] d);
        set_req(i, a, w, d);
        for (int n = 0; n < 40 && req_valid[i]; n++) begin
            tick();
            if (gnt_cyc[i] == cyc - 1) req_valid[i] = 1'b0;
        end
        check("grant_timeout", 32'(req_valid[i]), 32'd0);
        req_valid[i] = 1'b0;
        wait_idle();
    endtask

    task automatic run_random(input int ncyc, input int p_new, input int p_drop);
        for (int n = 0; n < ncyc; n++) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (gnt_cyc[i] == cyc - 1) req_valid[i] = 1'b0;
                if (!req_valid[i]) begin
                    if ($urandom_range(0, 99) < p_new)
                        set_req(i, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 8'($urandom));
                end else if ($urandom_range(0, 99) < p_drop) begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        req_valid = '0;
        wait_idle();
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1;
        req_valid = '1;
        req_addr  = '0;
        req_write = '1;
        req_wdata = '0;
        tick(); tick();
        #3;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_outputs", {21'd0, rsp_valid, busy, mm_enable, mm_read, mm_write, rsp_err}, 32'd0);
        check("rst_mm", {22'd0, mm_addr, mm_wdata}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        req_addr = 8'b10_10_10_10;
        req_write = '0;

        // all requesters held: grants rotate 0,1,2,3,0
        run_random(24, 100, 0);

        // directed: write FIFO, read it back from another requester, bad address
        do_req(0, 2'd0, 1'b1, 8'hA5);
        do_req(2, 2'd0, 1'b0, 8'h00);
        do_req(1, 2'd3, 1'b0, 8'h00);
        do_req(3, 2'd2, 1'b1, 8'h3C);
        do_req(0, 2'd2, 1'b0, 8'h00);

        // reset during ISSUE drops the transaction, priority returns to requester 0
        set_req(0, 2'd2, 1'b0, 8'h00);
        n = 0;
        while (gnt_cyc[0] != cyc - 1 && n < 20) begin tick(); n++; end
        req_valid[0] = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (3) tick();
        set_req(2, 2'd1, 1'b0, 8'h00);
        set_req(0, 2'd1, 1'b0, 8'h00);
        n = 0;
        while (req_valid != '0 && n < 40) begin
            tick(); n++;
            for (int i = 0; i < NREQ; i++) if (gnt_cyc[i] == cyc - 1) req_valid[i] = 1'b0;
        end
        check("regrant_order", 32'(gnt_cyc[0] < gnt_cyc[2]), 32'd1);
        wait_idle();

        run_random(1500, 30, 5);

`ifdef MM_FULL_GUARD_EN
        pulse_reset();
        do_req(1, 2'd0, 1'b0, 8'h00);
        for (int k = 0; k < DEPTH + 1; k++) do_req(k % NREQ, 2'd0, 1'b1, 8'(k + 8'h10));
        for (int k = 0; k < DEPTH + 1; k++) do_req(k % NREQ, 2'd0, 1'b0, 8'h00);
        run_random(400, 40, 5);
`endif

        repeat (8) tick();
        check("pending_rsp", 32'(rsp_q.size()), 32'd0);
        check("rsp_activity", 32'(rsp_seen > 20), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
